// File: rtl/s_block_pkg.sv
// Shared status codes and command encodings for the slave responder and its master-side peer.
package s_block_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_RDATA = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/s_regfile.sv
// Local register file: synchronous write, combinational read, contents untouched by reset.
// Single address port; the responder reads and writes only its latched request address.
module s_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/s_block.sv
// Slave responder: captures one request, acks LATENCY+1 cycles after capture, holds read data until consumed.
// No back-pressure beyond withholding ack; requests arriving while busy are dropped, not queued.
module s_block
  import s_block_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              master_in,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              data_read,
  output logic              ack,
  output logic              ack_master,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [1:0]        req_stat
);

  typedef struct packed {
    logic              master;
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              armed;
  req_t              lat;
  logic              capture;
  logic              enter_done;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  assign capture    = (state == ST_IDLE) && req && armed;
  assign enter_done = (state == ST_BUSY) && (cnt == 4'd0);
  // Reset on the same edge aborts the write.
  assign mem_we     = enter_done && (lat.cmd == CMD_WRITE) && !rst;
  assign req_stat   = state;

  s_regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk  (clk),
    .we   (mem_we),
    .addr (lat.addr),
    .wdata(lat.wdata),
    .rdata(mem_rd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req && armed) state_nxt = ST_BUSY;
      ST_BUSY:  if (cnt == 4'd0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = (lat.cmd == CMD_WRITE) ? ST_IDLE : ST_RDATA;
      ST_RDATA: if (data_read) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      armed      <= 1'b1;
      lat        <= '0;
      ack        <= 1'b0;
      ack_master <= 1'b0;
      rdata      <= '0;
      rvalid     <= 1'b0;
    end else begin
      ack <= enter_done;

      if (capture) begin
        lat <= {master_in, cmd, addr, wdata};
        cnt <= LAT;
      end else if ((state == ST_BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      // A low req re-arms even on the DONE-entry edge; a req held high stays disarmed.
      if (!req) begin
        armed <= 1'b1;
      end else if (enter_done) begin
        armed <= 1'b0;
      end

      if (enter_done) begin
        ack_master <= lat.master;
        if (lat.cmd == CMD_READ) begin
          rdata  <= mem_rd;
          rvalid <= 1'b1;
        end
      end

      if ((state == ST_RDATA) && data_read) rvalid <= 1'b0;
    end
  end

endmodule
